// File: rtl/display_scan_ctrl_if.sv
// Bus between the display scanner and its host / seven-segment decoder.
// The host side (master) supplies the BCD word and display controls; the
// scanner side (slave) returns the current digit, its index and the anodes.
interface display_scan_ctrl_if;
  logic [15:0] digits_in;
  logic        load;
  logic        blank_lz;
  logic        blink_en;
  logic [1:0]  sel;
  logic [3:0]  d;
  logic [1:0]  cnt;
  logic [3:0]  an;
  logic        frame_done;
  logic        pending;

  modport master (
    output digits_in, load, blank_lz, blink_en, sel,
    input  d, cnt, an, frame_done, pending
  );

  modport slave (
    input  digits_in, load, blank_lz, blink_en, sel,
    output d, cnt, an, frame_done, pending
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scanner. A prescaler sets the dwell time of each
// digit slot; the displayed word lives in a shadow register that is only
// updated at frame boundaries so a frame never mixes old and new digits.
// Leading-zero blanking and single-digit blink gate the active-low anodes.
module display_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                 clk,
  input  logic                 rst_n,
  display_scan_ctrl_if.slave   bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] presc_q;
  logic [1:0]    cnt_q;
  logic [15:0]   shadow_q;
  logic [15:0]   pend_buf_q;
  logic          pending_q;
  logic          frame_done_q;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;

  logic          tick;
  logic          frame_edge;
  logic          z1, z2, z3;
  logic          lz_blank;
  logic          blink_off;

  assign tick       = (presc_q == PW'(SCAN_DIV - 1));
  assign frame_edge = tick && (cnt_q == 2'd3);

  // Prescaler: one tick per digit slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Digit counter advances each slot and wraps to 0 at the frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= 2'd0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_edge;
      if (tick) begin
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

  // Double buffer: a load lands in the pending buffer and is promoted at the
  // next boundary; a load on the boundary itself goes straight to the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q   <= 16'h0000;
      pend_buf_q <= 16'h0000;
      pending_q  <= 1'b0;
    end else if (frame_edge && bus.load) begin
      shadow_q   <= bus.digits_in;
      pend_buf_q <= bus.digits_in;
      pending_q  <= 1'b0;
    end else if (frame_edge && pending_q) begin
      shadow_q   <= pend_buf_q;
      pending_q  <= 1'b0;
    end else if (bus.load) begin
      pend_buf_q <= bus.digits_in;
      pending_q  <= 1'b1;
    end
  end

  // Blink timebase: counts frames while enabled, held at zero otherwise so a
  // fresh enable always begins with a full visible half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (!bus.blink_en) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (frame_edge) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end
  end

  // Suppression: a digit is a leading zero when it and every higher digit are
  // zero; digit 0 always shows. Blink hides the selected slot in the off phase.
  always_comb begin
    z3        = (shadow_q[15:12] == 4'h0);
    z2        = z3 && (shadow_q[11:8] == 4'h0);
    z1        = z2 && (shadow_q[7:4] == 4'h0);
    lz_blank  = 1'b0;
    case (cnt_q)
      2'd1:    lz_blank = bus.blank_lz && z1;
      2'd2:    lz_blank = bus.blank_lz && z2;
      2'd3:    lz_blank = bus.blank_lz && z3;
      default: lz_blank = 1'b0;
    endcase
    blink_off = bus.blink_en && blink_phase_q && (cnt_q == bus.sel);
  end

  assign bus.d          = shadow_q[{cnt_q, 2'b00} +: 4];
  assign bus.cnt        = cnt_q;
  assign bus.an         = (lz_blank || blink_off) ? 4'b1111 : ~(4'b0001 << cnt_q);
  assign bus.frame_done = frame_done_q;
  assign bus.pending    = pending_q;

endmodule
